fetch_unit: RTL and testbench

Instruction fetch stage that produces the instruction word consumed by the decode-stage control logic. It is the producer end of the InstrD interface.
- Keeps the fetch PC and issues in-order requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small prefetch queue.
- Drives the IF/ID register: InstrD, PCD, PCPlus4D, ValidD.
- Honours decode stalls and execute-stage redirects (taken branch/jump).

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, credit-limited imem requests, prefetch
// queue with bypass, and the IF/ID pipeline register feeding decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRValid,
    input  logic [31:0] ImemRData,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);
    localparam int unsigned PW  = $clog2(QDEPTH);
    localparam int unsigned CW  = $clog2(QDEPTH + 1);
    localparam logic [CW:0] QD  = (CW + 1)'(QDEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pcf_q, pcf_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [31:0]   tag_pc_q [QDEPTH];
    logic [PW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

    logic [31:0]   q_instr_q [QDEPTH];
    logic [31:0]   q_pc_q    [QDEPTH];
    logic [PW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [CW-1:0] q_cnt_q, q_cnt_d;

    logic [31:0]   instr_q, instr_d;
    logic [31:0]   pcd_q, pcd_d;
    logic [31:0]   pcp4_q, pcp4_d;
    logic          valid_q, valid_d;

    logic [CW:0]   inflight;
    logic          req, grant, rsp_keep, ifid_load, q_empty;
    logic          bypass, q_push, q_pop;
    logic [31:0]   tag_head;

    always_comb begin
        // Credits cover both in-flight requests and queued words, so a
        // response always has a queue slot waiting for it.
        inflight  = (CW + 1)'(out_q) + (CW + 1)'(q_cnt_q);
        req       = reset_n && !PCSrcE && (inflight < QD);
        grant     = req && ImemGnt;
        rsp_keep  = ImemRValid && (drop_q == '0) && !PCSrcE;
        ifid_load = !PCSrcE && !StallD;
        q_empty   = (q_cnt_q == '0);
        bypass    = rsp_keep && q_empty && ifid_load;
        q_push    = rsp_keep && !bypass;
        q_pop     = ifid_load && !q_empty;
        tag_head  = tag_pc_q[tag_rd_q];

        pcf_d    = pcf_q;
        out_d    = out_q + CW'(grant) - CW'(ImemRValid);
        drop_d   = drop_q;
        tag_wr_d = tag_wr_q + PW'(grant);
        tag_rd_d = tag_rd_q + PW'(ImemRValid);
        q_wr_d   = q_wr_q + PW'(q_push);
        q_rd_d   = q_rd_q + PW'(q_pop);
        q_cnt_d  = q_cnt_q + CW'(q_push) - CW'(q_pop);
        instr_d  = instr_q;
        pcd_d    = pcd_q;
        pcp4_d   = pcp4_q;
        valid_d  = valid_q;

        if (PCSrcE) begin
            pcf_d   = PCTargetE & ~32'h3;
            drop_d  = out_q - CW'(ImemRValid);
            q_wr_d  = '0;
            q_rd_d  = '0;
            q_cnt_d = '0;
        end else begin
            if (grant) begin
                pcf_d = pcf_q + 32'd4;
            end
            if (ImemRValid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
        end

        if (PCSrcE) begin
            valid_d = 1'b0;
            instr_d = NOP;
        end else if (StallD) begin
            valid_d = valid_q;
        end else if (q_pop) begin
            instr_d = q_instr_q[q_rd_q];
            pcd_d   = q_pc_q[q_rd_q];
            pcp4_d  = q_pc_q[q_rd_q] + 32'd4;
            valid_d = 1'b1;
        end else if (bypass) begin
            instr_d = ImemRData;
            pcd_d   = tag_head;
            pcp4_d  = tag_head + 32'd4;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
            instr_d = NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcf_q    <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            q_wr_q   <= '0;
            q_rd_q   <= '0;
            q_cnt_q  <= '0;
            instr_q  <= NOP;
            pcd_q    <= '0;
            pcp4_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            pcf_q    <= pcf_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
            q_wr_q   <= q_wr_d;
            q_rd_q   <= q_rd_d;
            q_cnt_q  <= q_cnt_d;
            instr_q  <= instr_d;
            pcd_q    <= pcd_d;
            pcp4_q   <= pcp4_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            tag_pc_q[tag_wr_q] <= pcf_q;
        end
        if (q_push) begin
            q_instr_q[q_wr_q] <= ImemRData;
            q_pc_q[q_wr_q]    <= tag_head;
        end
    end

    assign ImemReq  = req;
    assign ImemAddr = pcf_q;
    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;

    a_rsp_has_outstanding: assert property (
        @(posedge clk) disable iff (!reset_n) ImemRValid |-> (out_q != '0)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order instruction memory model
// of programmable latency returning PC|1 as the instruction word.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt = 1'b0;
    logic        ImemRValid = 1'b0;
    logic [31:0] ImemRData = '0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        StallD = 1'b0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned lat = 1;
    int unsigned cyc = 0;
    logic [31:0] pend_addr [$];
    int unsigned pend_due  [$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRValid(ImemRValid), .ImemRData(ImemRData),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    // Memory: grants sampled mid-cycle, responses presented just after the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pend_addr.delete();
                pend_due.delete();
            end else begin
                if (ImemRValid && pend_addr.size() > 0) begin
                    void'(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                end
                if (ImemReq && ImemGnt) begin
                    pend_addr.push_back(ImemAddr);
                    pend_due.push_back(cyc + lat);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                ImemRValid = 1'b1;
                ImemRData  = pend_addr[0] | 32'h1;
            end else begin
                ImemRValid = 1'b0;
                ImemRData  = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ImemGnt = 1'b1;
        lat     = 1;
        tick(); tick(); #1;
        n_cmp++; if (ImemReq !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", ImemReq); end
        n_cmp++; if (ValidD !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", ValidD); end
        n_cmp++; if (InstrD !== 32'h13) begin n_bad++; $display("FAIL reset_instr: got %h want 00000013", InstrD); end
        n_cmp++; if (PCD !== 32'h0) begin n_bad++; $display("FAIL reset_pcd: got %h want 0", PCD); end
        n_cmp++; if (PCPlus4D !== 32'h0) begin n_bad++; $display("FAIL reset_pcp4: got %h want 0", PCPlus4D); end
        n_cmp++; if (ImemAddr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", ImemAddr); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        tick();
        reset_n = 1'b1;
        #1;
        n_cmp++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin n_bad++; $display("FAIL stream_first_req: got %b/%h want 1/0", ImemReq, ImemAddr); end
        tick(); #1;
        n_cmp++; if (ValidD !== 1'b0) begin n_bad++; $display("FAIL stream_bubble: got %b want 0", ValidD); end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            e = 32'(4 * i);
            n_cmp++; if (ValidD !== 1'b1 || PCD !== e || InstrD !== (e | 32'h1) || PCPlus4D !== e + 32'd4) begin
                n_bad++; $display("FAIL stream_%0d: got v=%b pc=%h in=%h p4=%h want 1/%h/%h/%h", i, ValidD, PCD, InstrD, PCPlus4D, e, e | 32'h1, e + 32'd4);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        StallD = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            n_cmp++; if (ImemReq !== 1'b0 || PCD !== 32'h8 || ValidD !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold_%0d: got req=%b pc=%h v=%b want 0/8/1", i, ImemReq, PCD, ValidD);
            end
        end
        tick();
        StallD = 1'b0;
        #1;
        n_cmp++; if (ImemReq !== 1'b0 || PCD !== 32'h8) begin n_bad++; $display("FAIL stall_full: got req=%b pc=%h want 0/8", ImemReq, PCD); end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            e = 32'(12 + 4 * i);
            n_cmp++; if (ValidD !== 1'b1 || PCD !== e || InstrD !== (e | 32'h1)) begin
                n_bad++; $display("FAIL stall_release_%0d: got v=%b pc=%h in=%h want 1/%h/%h", i, ValidD, PCD, InstrD, e, e | 32'h1);
            end
        end
    endtask

    task automatic test_gnt_stall();
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(); #1;
            if (ImemReq === 1'b1 && ImemAddr === 32'h20) found = 1;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL gnt_reach: got no request at 20 want request at 20"); end
        ImemGnt = 1'b0;
        for (int i = 1; i < 4; i++) begin
            tick(); #1;
            n_cmp++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h20) begin
                n_bad++; $display("FAIL gnt_hold_%0d: got %b/%h want 1/00000020", i, ImemReq, ImemAddr);
            end
        end
        tick();
        ImemGnt = 1'b1;
        #1;
        n_cmp++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h20) begin n_bad++; $display("FAIL gnt_last: got %b/%h want 1/00000020", ImemReq, ImemAddr); end
        tick(); #1;
        n_cmp++; if (ImemAddr !== 32'h24) begin n_bad++; $display("FAIL gnt_advance: got %h want 00000024", ImemAddr); end
    endtask

    task automatic test_redirect();
        ImemGnt = 1'b0;
        repeat (4) tick();
        lat     = 2;
        ImemGnt = 1'b1;
        tick();
        tick();
        PCSrcE    = 1'b1;
        PCTargetE = 32'h103;
        #1;
        n_cmp++; if (ImemReq !== 1'b0) begin n_bad++; $display("FAIL redir_req: got %b want 0", ImemReq); end
        n_cmp++; if (pend_addr.size() != 2) begin n_bad++; $display("FAIL redir_outstanding: got %0d want 2", pend_addr.size()); end
        tick();
        PCSrcE = 1'b0;
        #1;
        n_cmp++; if (ValidD !== 1'b0 || InstrD !== 32'h13) begin n_bad++; $display("FAIL redir_flush: got %b/%h want 0/00000013", ValidD, InstrD); end
        n_cmp++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h100) begin n_bad++; $display("FAIL redir_target: got %b/%h want 1/00000100", ImemReq, ImemAddr); end
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            n_cmp++; if (ValidD !== 1'b0) begin n_bad++; $display("FAIL redir_drop_%0d: got v=%b pc=%h want v=0", i, ValidD, PCD); end
        end
        tick(); #1;
        n_cmp++; if (ValidD !== 1'b1 || PCD !== 32'h100 || InstrD !== 32'h101 || PCPlus4D !== 32'h104) begin
            n_bad++; $display("FAIL redir_first: got %b/%h/%h/%h want 1/00000100/00000101/00000104", ValidD, PCD, InstrD, PCPlus4D);
        end
    endtask

    task automatic test_flush_stall();
        bit got = 0;
        lat       = 1;
        PCSrcE    = 1'b1;
        StallD    = 1'b1;
        PCTargetE = 32'h200;
        tick();
        PCSrcE = 1'b0;
        StallD = 1'b0;
        #1;
        n_cmp++; if (ValidD !== 1'b0 || InstrD !== 32'h13) begin n_bad++; $display("FAIL flush_wins: got %b/%h want 0/00000013", ValidD, InstrD); end
        n_cmp++; if (ImemAddr !== 32'h200) begin n_bad++; $display("FAIL flush_addr: got %h want 00000200", ImemAddr); end
        for (int i = 0; i < 10 && !got; i++) begin
            tick(); #1;
            if (ValidD === 1'b1) got = 1;
        end
        n_cmp++; if (!got || PCD !== 32'h200 || InstrD !== 32'h201) begin
            n_bad++; $display("FAIL flush_first: got v=%b pc=%h in=%h want 1/00000200/00000201", ValidD, PCD, InstrD);
        end
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        int unsigned n = 0;
        logic [31:0] e;
        lat = 2;
        for (int i = 0; i < 10 && !hit; i++) begin
            tick(); #1;
            if (pend_addr.size() == 2) hit = 1;
        end
        n_cmp++; if (!hit) begin n_bad++; $display("FAIL rstmid_setup: got <2 outstanding want 2"); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (ImemReq !== 1'b0) begin n_bad++; $display("FAIL rstmid_req_low: got %b want 0", ImemReq); end
        tick();
        reset_n = 1'b1;
        #1;
        n_cmp++; if (ValidD !== 1'b0 || InstrD !== 32'h13 || PCD !== 32'h0 || PCPlus4D !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_outputs: got %b/%h/%h/%h want 0/00000013/0/0", ValidD, InstrD, PCD, PCPlus4D);
        end
        n_cmp++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin n_bad++; $display("FAIL rstmid_req: got %b/%h want 1/0", ImemReq, ImemAddr); end
        for (int i = 0; i < 30 && n < 3; i++) begin
            tick(); #1;
            if (ValidD === 1'b1) begin
                e = 32'(4 * n);
                n_cmp++; if (PCD !== e || InstrD !== (e | 32'h1)) begin
                    n_bad++; $display("FAIL rstmid_seq_%0d: got pc=%h in=%h want %h/%h", n, PCD, InstrD, e, e | 32'h1);
                end
                n++;
            end
        end
        n_cmp++; if (n != 3) begin n_bad++; $display("FAIL rstmid_count: got %0d want 3", n); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_gnt_stall();
        test_redirect();
        test_flush_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
